mix_column: RTL and testbench

- AES MixColumns round stage.
- Takes a 4x4 byte state that has already been ShiftRows-permuted, and multiplies each column by the fixed GF(2^8) matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
- Drives a registered 16-byte result.
- Sits between the ShiftRows and AddRoundKey stages of the encryption datapath.

---
 rtl/mix_column.sv | 89 ++++++++
 tb/tb_mix_column.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mix_column.sv
// AES MixColumns round stage: multiplies each column of the ShiftRows-permuted
// state by the fixed GF(2^8) matrix and registers the 16-byte result.
module mix_column (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] r11,
    input  logic [7:0] r12,
    input  logic [7:0] r13,
    input  logic [7:0] r14,
    input  logic [7:0] r21,
    input  logic [7:0] r22,
    input  logic [7:0] r23,
    input  logic [7:0] r24,
    input  logic [7:0] r31,
    input  logic [7:0] r32,
    input  logic [7:0] r33,
    input  logic [7:0] r34,
    input  logic [7:0] r41,
    input  logic [7:0] r42,
    input  logic [7:0] r43,
    input  logic [7:0] r44,
    output logic [7:0] c1,
    output logic [7:0] c2,
    output logic [7:0] c3,
    output logic [7:0] c4,
    output logic [7:0] c5,
    output logic [7:0] c6,
    output logic [7:0] c7,
    output logic [7:0] c8,
    output logic [7:0] c9,
    output logic [7:0] c10,
    output logic [7:0] c11,
    output logic [7:0] c12,
    output logic [7:0] c13,
    output logic [7:0] c14,
    output logic [7:0] c15,
    output logic [7:0] c16
);

    // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // col[j][i] = row i, column j of the input state
    logic [7:0] col [4][4];
    logic [7:0] res_d [16];
    logic [7:0] res_q [16];

    // Gather the input state column by column
    always_comb begin
        col[0][0] = r11; col[0][1] = r21; col[0][2] = r31; col[0][3] = r41;
        col[1][0] = r12; col[1][1] = r22; col[1][2] = r32; col[1][3] = r42;
        col[2][0] = r13; col[2][1] = r23; col[2][2] = r33; col[2][3] = r43;
        col[3][0] = r14; col[3][1] = r24; col[3][2] = r34; col[3][3] = r44;
    end

    // Mix all four columns in parallel; 3*x is formed as 2*x ^ x
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            res_d[4*j+0] = xtime(col[j][0]) ^ xtime(col[j][1]) ^ col[j][1]
                         ^ col[j][2] ^ col[j][3];
            res_d[4*j+1] = col[j][0] ^ xtime(col[j][1]) ^ xtime(col[j][2])
                         ^ col[j][2] ^ col[j][3];
            res_d[4*j+2] = col[j][0] ^ col[j][1] ^ xtime(col[j][2])
                         ^ xtime(col[j][3]) ^ col[j][3];
            res_d[4*j+3] = xtime(col[j][0]) ^ col[j][0] ^ col[j][1]
                         ^ col[j][2] ^ xtime(col[j][3]);
        end
    end

    // Single result register bank, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) res_q[k] <= 8'h00;
        end else begin
            for (int k = 0; k < 16; k++) res_q[k] <= res_d[k];
        end
    end

    // Column-major output mapping
    always_comb begin
        c1  = res_q[0];  c2  = res_q[1];  c3  = res_q[2];  c4  = res_q[3];
        c5  = res_q[4];  c6  = res_q[5];  c7  = res_q[6];  c8  = res_q[7];
        c9  = res_q[8];  c10 = res_q[9];  c11 = res_q[10]; c12 = res_q[11];
        c13 = res_q[12]; c14 = res_q[13]; c15 = res_q[14]; c16 = res_q[15];
    end

endmodule

// File: tb/tb_mix_column.sv
// Directed and randomized checks of the MixColumns stage against hand-computed
// vectors and an independent shift-and-add GF(2^8) multiplier model.
module tb_mix_column;

    logic       clk;
    logic       rst_n;
    logic [7:0] r [4][4];   // r[row][col]
    logic [7:0] c [16];
    logic [7:0] exp_v [16];

    int compared;
    int mismatched;

    mix_column dut (
        .clk  (clk),
        .rst_n(rst_n),
        .r11(r[0][0]), .r12(r[0][1]), .r13(r[0][2]), .r14(r[0][3]),
        .r21(r[1][0]), .r22(r[1][1]), .r23(r[1][2]), .r24(r[1][3]),
        .r31(r[2][0]), .r32(r[2][1]), .r33(r[2][2]), .r34(r[2][3]),
        .r41(r[3][0]), .r42(r[3][1]), .r43(r[3][2]), .r44(r[3][3]),
        .c1 (c[0]),  .c2 (c[1]),  .c3 (c[2]),  .c4 (c[3]),
        .c5 (c[4]),  .c6 (c[5]),  .c7 (c[6]),  .c8 (c[7]),
        .c9 (c[8]),  .c10(c[9]),  .c11(c[10]), .c12(c[11]),
        .c13(c[12]), .c14(c[13]), .c15(c[14]), .c16(c[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply, shift-and-add with 0x11B reduction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Expected outputs for the inputs currently applied
    task automatic model();
        logic [7:0] m [4][4];
        m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                exp_v[4*j+i] = 8'h00;
                for (int k = 0; k < 4; k++)
                    exp_v[4*j+i] = exp_v[4*j+i] ^ gf_mul(m[i][k], r[k][j]);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_col(input string tag, input int j, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3);
        check($sformatf("%s c%0d", tag, 4*j+1), c[4*j+0], e0);
        check($sformatf("%s c%0d", tag, 4*j+2), c[4*j+1], e1);
        check($sformatf("%s c%0d", tag, 4*j+3), c[4*j+2], e2);
        check($sformatf("%s c%0d", tag, 4*j+4), c[4*j+3], e3);
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 16; k++) check($sformatf("%s c%0d", tag, k+1), c[k], exp_v[k]);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 16; k++) check($sformatf("%s c%0d", tag, k+1), c[k], 8'h00);
    endtask

    task automatic set_col(input int j, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, input logic [7:0] e);
        r[0][j] = a; r[1][j] = b; r[2][j] = d; r[3][j] = e;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset held with arbitrary inputs across clock edges
        rst_n = 1'b0;
        set_rand();
        tick();
        tick();
        check_zero("reset");

        // FIPS-197 state
        @(negedge clk);
        rst_n = 1'b1;
        set_col(0, 8'hdb, 8'h13, 8'h53, 8'h45);
        set_col(1, 8'h01, 8'h01, 8'h01, 8'h01);
        set_col(2, 8'hd4, 8'hd4, 8'hd4, 8'hd5);
        set_col(3, 8'h2d, 8'h26, 8'h31, 8'h4c);
        tick();
        check_col("fips", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);
        check_col("fips", 1, 8'h01, 8'h01, 8'h01, 8'h01);
        check_col("fips", 2, 8'hd5, 8'hd5, 8'hd7, 8'hd6);
        check_col("fips", 3, 8'h4d, 8'h7e, 8'hbd, 8'hf8);

        // Asynchronous reset between edges, then clean recapture
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_col("post_rst", 0, 8'h8e, 8'h4d, 8'ha1, 8'hbc);

        // Vector A, other columns random
        set_rand();
        set_col(0, 8'h01, 8'hb2, 8'hb7, 8'hd4);
        model();
        tick();
        check_col("vec_a", 0, 8'hac, 8'h68, 8'ha1, 8'hb5);
        check_model("vec_a_model");

        // Back-to-back: outputs must not move before the next edge
        set_col(0, 8'h23, 8'hc7, 8'h42, 8'h3a);
        #1;
        check_col("hold_pre_edge", 0, 8'hac, 8'h68, 8'ha1, 8'hb5);
        tick();
        check_col("b2b", 0, 8'h6c, 8'h4a, 8'h2e, 8'h94);

        // Holding inputs holds outputs
        tick();
        check_col("hold", 0, 8'h6c, 8'h4a, 8'h2e, 8'h94);

        // Reduction corners
        set_all(8'hff);
        tick();
        for (int j = 0; j < 4; j++) check_col("all_ff", j, 8'hff, 8'hff, 8'hff, 8'hff);
        set_all(8'h00);
        tick();
        check_zero("all_00");
        set_col(0, 8'h80, 8'h00, 8'h00, 8'h00);
        tick();
        check_col("msb", 0, 8'h1b, 8'h80, 8'h80, 8'h9b);

        // Random stream with occasional reset pulses
        for (int n = 0; n < 1000; n++) begin
            if (n % 97 == 50) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            set_rand();
            model();
            tick();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
